// File: rtl/and4_pkg.sv
// Shared constants for the and4 leaf gate: default lane count, popcount width
// helper and the reset values of the observation registers.
package and4_pkg;

  localparam int WIDTH_DEF = 4;

  // Enough bits to hold 0..w, so the popcount never wraps.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam logic [WIDTH_DEF-1:0] ACC_RST = '1;
  localparam logic [WIDTH_DEF-1:0] YQ_RST  = '0;

endpackage

// File: rtl/and4_popcount.sv
// Population count of a WIDTH-bit vector; used to decode the captured AND result.
module popcount #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic [WIDTH-1:0] bits_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_o = cnt_o + CNT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/and4.sv
// Bitwise AND gate with a registered observation stage: captured copy,
// reduction flags, popcount and a running-AND accumulator.
module and4
  import and4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] y_q,
  output logic             y_vld,
  output logic             y_any,
  output logic             y_all,
  output logic [CNT_W-1:0] y_cnt,
  output logic [WIDTH-1:0] acc
);

  // Package reset values are defined per lane pattern so any WIDTH reuses them.
  localparam logic [WIDTH-1:0] ACC_INIT = {WIDTH{ACC_RST[0]}};
  localparam logic [WIDTH-1:0] YQ_INIT  = {WIDTH{YQ_RST[0]}};

  logic [WIDTH-1:0] yq_q, yq_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             vld_q, vld_d;

  assign y = a & b;

  always_comb begin
    yq_d  = yq_q;
    vld_d = vld_q;
    acc_d = acc_q;
    if (en) begin
      yq_d  = y;
      vld_d = 1'b1;
      acc_d = acc_q & y;
    end
    // Clear wins over an accumulate in the same cycle; the capture is not folded in.
    if (clr) begin
      acc_d = ACC_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      yq_q  <= YQ_INIT;
      vld_q <= 1'b0;
      acc_q <= ACC_INIT;
    end else begin
      yq_q  <= yq_d;
      vld_q <= vld_d;
      acc_q <= acc_d;
    end
  end

  assign y_q   = yq_q;
  assign y_vld = vld_q;
  assign acc   = acc_q;
  assign y_any = |yq_q;
  assign y_all = &yq_q;

  popcount #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_popcount (
    .bits_i(yq_q),
    .cnt_o (y_cnt)
  );

endmodule

// File: tb/tb_and4.sv
// Directed, table-driven bench for and4: combinational sweep, then clocked
// sequences covering reset, capture, hold, clear priority and mid-stream reset.
module tb_and4;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst = 1'b0, en = 1'b0, clr = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic [3:0] y, y_q, acc;
  logic       y_vld, y_any, y_all;
  logic [2:0] y_cnt;

  int errors = 0;
  int checks = 0;

  and4 #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .y(y), .en(en), .clr(clr),
    .y_q(y_q), .y_vld(y_vld), .y_any(y_any), .y_all(y_all),
    .y_cnt(y_cnt), .acc(acc)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] ey;
  } comb_t;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       clr;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] ey;
    logic [3:0] eyq;
    logic       evld;
    logic       eany;
    logic       eall;
    logic [2:0] ecnt;
    logic [3:0] eacc;
  } seq_t;

  // Drive on the falling edge, check y before the rising edge, registers after it.
  task automatic step(input seq_t v, input string tag);
    @(negedge clk);
    rst = v.rst; en = v.en; clr = v.clr; a = v.a; b = v.b;
    #1;
    chk({tag, ".y"}, 32'(y), 32'(v.ey));
    @(posedge clk);
    #1;
    chk({tag, ".y_q"},   32'(y_q),   32'(v.eyq));
    chk({tag, ".y_vld"}, 32'(y_vld), 32'(v.evld));
    chk({tag, ".y_any"}, 32'(y_any), 32'(v.eany));
    chk({tag, ".y_all"}, 32'(y_all), 32'(v.eall));
    chk({tag, ".y_cnt"}, 32'(y_cnt), 32'(v.ecnt));
    chk({tag, ".acc"},   32'(acc),   32'(v.eacc));
    chk({tag, ".y_post"}, 32'(y),    32'(v.ey));
  endtask

  comb_t cv [4];
  seq_t  sv [11];

  initial begin
    cv[0] = '{4'b0000, 4'b0000, 4'b0000};
    cv[1] = '{4'b1010, 4'b0101, 4'b0000};
    cv[2] = '{4'b1111, 4'b1111, 4'b1111};
    cv[3] = '{4'b1100, 4'b1010, 4'b1000};

    //          rst en clr a        b        y        y_q      vld any all cnt   acc
    sv[0]  = '{1'b1, 1'b1, 1'b0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 4'b1111};
    sv[1]  = '{1'b0, 1'b1, 1'b0, 4'b1100, 4'b1010, 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b0, 3'd1, 4'b1000};
    sv[2]  = '{1'b0, 1'b1, 1'b0, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 3'd4, 4'b1000};
    sv[3]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1, 3'd4, 4'b1000};
    sv[4]  = '{1'b0, 1'b1, 1'b1, 4'b0011, 4'b1111, 4'b0011, 4'b0011, 1'b1, 1'b1, 1'b0, 3'd2, 4'b1111};
    sv[5]  = '{1'b0, 1'b1, 1'b0, 4'b0110, 4'b0111, 4'b0110, 4'b0110, 1'b1, 1'b1, 1'b0, 3'd2, 4'b0110};
    sv[6]  = '{1'b0, 1'b0, 1'b1, 4'b1001, 4'b1001, 4'b1001, 4'b0110, 1'b1, 1'b1, 1'b0, 3'd2, 4'b1111};
    sv[7]  = '{1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 4'b1111};
    sv[8]  = '{1'b0, 1'b0, 1'b0, 4'b0111, 4'b0111, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 4'b1111};
    sv[9]  = '{1'b0, 1'b1, 1'b0, 4'b0101, 4'b1101, 4'b0101, 4'b0101, 1'b1, 1'b1, 1'b0, 3'd2, 4'b0101};
    sv[10] = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000};

    // Combinational sweep with the clock stopped.
    for (int i = 0; i < 4; i++) begin
      a = cv[i].a; b = cv[i].b;
      #10;
      chk($sformatf("comb%0d.y", i), 32'(y), 32'(cv[i].ey));
    end

    clk_run = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step(sv[i], $sformatf("seq%0d", i));
    end

    // Clear held with capture, then a chain of accumulates.
    step('{1'b0, 1'b1, 1'b1, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 3'd4, 4'b1111}, "chain0");
    step('{1'b0, 1'b1, 1'b0, 4'b1110, 4'b1111, 4'b1110, 4'b1110, 1'b1, 1'b1, 1'b0, 3'd3, 4'b1110}, "chain1");
    step('{1'b0, 1'b1, 1'b0, 4'b0111, 4'b1111, 4'b0111, 4'b0111, 1'b1, 1'b1, 1'b0, 3'd3, 4'b0110}, "chain2");
    step('{1'b0, 1'b1, 1'b0, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 3'd4, 4'b0110}, "chain3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
